// File: rtl/miner_result_pkg.sv
// Shared constants and types for the miner result capture path.
// Status word field positions live here so host-side decoding stays in one place.
package miner_result_pkg;

   localparam int EPOCH_W     = 16;
   localparam int ST_NONEMPTY = 31;
   localparam int ST_OVERFLOW = 30;
   localparam int ST_COUNT    = 16;
   localparam int ST_COUNT_W  = 8;

   typedef struct packed {
      logic [31:0] nonce;
   } result_entry_t;

endpackage

// File: rtl/nonce_sync_fifo.sv
// Single-clock FIFO of result entries with flush, occupancy count and
// pop-enables-push so a full FIFO can accept a write in the same cycle as a read.
import miner_result_pkg::*;

module nonce_sync_fifo #(
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  result_entry_t din,
   output result_entry_t dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   result_entry_t mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == FULL_COUNT);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign dout    = empty ? result_entry_t'(32'h0000_0000) : mem[rd_ptr];

   // Storage, pointers and occupancy; flush overrides any push or pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      end
   end

endmodule

// File: rtl/nonce_result_fifo.sv
// Captures rising nonce_found edges per core into pending slots, round-robin
// serialises them into an epoch-tagged FIFO drained by the register read path.
import miner_result_pkg::*;

module nonce_result_fifo #(
   parameter int CORES = 2,
   parameter int DEPTH = 8
) (
   input  logic                  clk_main_a0,
   input  logic                  rst_main_n,
   input  logic                  new_block,
   input  logic [CORES-1:0]      nonce_found,
   input  logic [32*CORES-1:0]   nonce_in,
   input  logic                  pop,
   output logic [31:0]           head_nonce,
   output logic [31:0]           status,
   output logic                  found_irq
);

   localparam int PW = (CORES > 1) ? $clog2(CORES) : 1;
   localparam int AW = $clog2(DEPTH);

   logic [CORES-1:0]   prev_found;
   logic [CORES-1:0]   slot_valid;
   logic [CORES-1:0]   capture;
   logic [31:0]        slot_nonce [CORES];
   logic [PW-1:0]      rr_ptr;
   logic [PW-1:0]      grant_idx;
   logic               grant_valid;
   logic               do_grant;
   logic               overflow;
   logic [EPOCH_W-1:0] epoch;
   logic [31:0]        status_next;

   result_entry_t      fifo_din;
   result_entry_t      fifo_head;
   logic               fifo_full;
   logic               fifo_empty;
   logic [AW:0]        fifo_count;

   assign capture  = nonce_found & ~prev_found;
   assign do_grant = grant_valid && (!fifo_full || pop) && !new_block;
   assign fifo_din = result_entry_t'(slot_nonce[grant_idx]);

   // Round-robin pick of the first valid slot at or after rr_ptr.
   always_comb begin
      logic hit;
      int   idx;
      grant_valid = 1'b0;
      grant_idx   = '0;
      hit         = 1'b0;
      idx         = 0;
      for (int k = 0; k < CORES; k++) begin
         idx         = (int'(rr_ptr) + k) % CORES;
         hit         = !grant_valid && slot_valid[idx];
         grant_idx   = hit ? PW'(idx) : grant_idx;
         grant_valid = grant_valid | hit;
      end
   end

   // Edge detect, pending slots, arbiter pointer, overflow and epoch.
   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         prev_found <= '0;
         slot_valid <= '0;
         rr_ptr     <= '0;
         overflow   <= 1'b0;
         epoch      <= '0;
         for (int i = 0; i < CORES; i++) begin
            slot_nonce[i] <= 32'h0000_0000;
         end
      end else begin
         prev_found <= nonce_found;
         if (new_block) begin
            slot_valid <= '0;
            overflow   <= 1'b0;
            epoch      <= epoch + 1'b1;
         end else begin
            if (do_grant) begin
               rr_ptr <= PW'((int'(grant_idx) + 1) % CORES);
            end
            for (int i = 0; i < CORES; i++) begin
               // A slot being granted this cycle may be refilled without loss.
               if (capture[i]) begin
                  if (slot_valid[i] && !(do_grant && grant_idx == PW'(i))) begin
                     overflow <= 1'b1;
                  end else begin
                     slot_valid[i] <= 1'b1;
                     slot_nonce[i] <= nonce_in[32*i +: 32];
                  end
               end else if (do_grant && grant_idx == PW'(i)) begin
                  slot_valid[i] <= 1'b0;
               end
            end
         end
      end
   end

   nonce_sync_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk_main_a0),
      .rst_n (rst_main_n),
      .flush (new_block),
      .push  (do_grant),
      .pop   (pop && !new_block),
      .din   (fifo_din),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Status word assembly.
   always_comb begin
      status_next                             = 32'h0000_0000;
      status_next[ST_NONEMPTY]                = !fifo_empty;
      status_next[ST_OVERFLOW]                = overflow;
      status_next[ST_COUNT +: ST_COUNT_W]     = ST_COUNT_W'(fifo_count);
      status_next[EPOCH_W-1:0]                = epoch;
   end

   // Registered outputs; the previous status count detects the 0 -> non-zero step.
   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         head_nonce <= 32'h0000_0000;
         status     <= 32'h0000_0000;
         found_irq  <= 1'b0;
      end else begin
         head_nonce <= fifo_head.nonce;
         status     <= status_next;
         found_irq  <= (fifo_count != '0) && (status[ST_COUNT +: ST_COUNT_W] == 8'h00);
      end
   end

endmodule

// File: tb/tb_nonce_result_fifo.sv
// Directed self-checking bench for nonce_result_fifo (CORES=2, DEPTH=8).
module tb_nonce_result_fifo;

   logic        clk_main_a0 = 1'b0;
   logic        rst_main_n  = 1'b0;
   logic        new_block   = 1'b0;
   logic [1:0]  nonce_found = 2'b00;
   logic [63:0] nonce_in    = 64'h0;
   logic        pop         = 1'b0;
   logic [31:0] head_nonce;
   logic [31:0] status;
   logic        found_irq;

   int n_checks = 0;
   int n_fail   = 0;
   int irq_seen = 0;

   nonce_result_fifo #(.CORES(2), .DEPTH(8)) dut (
      .clk_main_a0 (clk_main_a0),
      .rst_main_n  (rst_main_n),
      .new_block   (new_block),
      .nonce_found (nonce_found),
      .nonce_in    (nonce_in),
      .pop         (pop),
      .head_nonce  (head_nonce),
      .status      (status),
      .found_irq   (found_irq)
   );

   always #5 clk_main_a0 = ~clk_main_a0;

   task automatic tick();
      @(posedge clk_main_a0);
      #1;
      if (found_irq === 1'b1) irq_seen++;
   endtask

   task automatic apply_reset();
      rst_main_n  = 1'b0;
      new_block   = 1'b0;
      nonce_found = 2'b00;
      nonce_in    = 64'h0;
      pop         = 1'b0;
      repeat (2) tick();
      rst_main_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++; if (head_nonce !== 32'h0) begin n_fail++; $display("FAIL reset_head: got %h expected %h", head_nonce, 32'h0); end
      n_checks++; if (status !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h expected %h", status, 32'h0); end
      n_checks++; if (found_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", found_irq); end
   endtask

   task automatic test_single_find();
      irq_seen = 0;
      nonce_found = 2'b01;
      nonce_in[31:0] = 32'h1234_5678;
      tick();
      tick();
      n_checks++; if (head_nonce !== 32'h0) begin n_fail++; $display("FAIL single_head_early: got %h expected %h", head_nonce, 32'h0); end
      tick();
      n_checks++; if (head_nonce !== 32'h1234_5678) begin n_fail++; $display("FAIL single_head: got %h expected %h", head_nonce, 32'h1234_5678); end
      n_checks++; if (status !== 32'h8001_0000) begin n_fail++; $display("FAIL single_status: got %h expected %h", status, 32'h8001_0000); end
      n_checks++; if (found_irq !== 1'b1) begin n_fail++; $display("FAIL single_irq: got %b expected 1", found_irq); end
      repeat (2) tick();
      nonce_found = 2'b00;
      repeat (3) tick();
      n_checks++; if (status !== 32'h8001_0000) begin n_fail++; $display("FAIL single_one_entry: got %h expected %h", status, 32'h8001_0000); end
      n_checks++; if (irq_seen !== 1) begin n_fail++; $display("FAIL single_irq_pulses: got %0d expected 1", irq_seen); end
      pop = 1'b1; tick(); pop = 1'b0; tick();
      n_checks++; if (head_nonce !== 32'h0 || status !== 32'h0) begin n_fail++; $display("FAIL single_drained: got %h/%h expected 0/0", head_nonce, status); end
   endtask

   task automatic test_simultaneous();
      apply_reset();
      nonce_found = 2'b11;
      nonce_in = {32'h0000_000B, 32'h0000_000A};
      repeat (4) tick();
      nonce_found = 2'b00;
      n_checks++; if (head_nonce !== 32'h0000_000A) begin n_fail++; $display("FAIL simul_first: got %h expected %h", head_nonce, 32'hA); end
      n_checks++; if (status !== 32'h8002_0000) begin n_fail++; $display("FAIL simul_count2: got %h expected %h", status, 32'h8002_0000); end
      pop = 1'b1; tick(); pop = 1'b0; tick();
      n_checks++; if (head_nonce !== 32'h0000_000B) begin n_fail++; $display("FAIL simul_second: got %h expected %h", head_nonce, 32'hB); end
      n_checks++; if (status !== 32'h8001_0000) begin n_fail++; $display("FAIL simul_count1: got %h expected %h", status, 32'h8001_0000); end
      pop = 1'b1; tick(); pop = 1'b0; tick();
      n_checks++; if (head_nonce !== 32'h0) begin n_fail++; $display("FAIL simul_empty_head: got %h expected %h", head_nonce, 32'h0); end
      n_checks++; if (status !== 32'h0) begin n_fail++; $display("FAIL simul_empty_status: got %h expected %h", status, 32'h0); end
   endtask

   task automatic test_full_overflow();
      logic [31:0] exp_head;
      apply_reset();
      for (int k = 0; k < 10; k++) begin
         nonce_found = 2'b10;
         nonce_in[63:32] = 32'h0000_0100 + k;
         tick();
         nonce_found = 2'b00;
         tick();
      end
      repeat (2) tick();
      n_checks++; if (status !== 32'hC008_0000) begin n_fail++; $display("FAIL full_status: got %h expected %h", status, 32'hC008_0000); end
      n_checks++; if (head_nonce !== 32'h0000_0100) begin n_fail++; $display("FAIL full_head: got %h expected %h", head_nonce, 32'h100); end
      pop = 1'b1; tick(); pop = 1'b0; tick();
      n_checks++; if (status !== 32'hC008_0000) begin n_fail++; $display("FAIL full_pop_grant_count: got %h expected %h", status, 32'hC008_0000); end
      n_checks++; if (head_nonce !== 32'h0000_0101) begin n_fail++; $display("FAIL full_pop_grant_head: got %h expected %h", head_nonce, 32'h101); end
      for (int k = 2; k <= 9; k++) begin
         exp_head = (k <= 8) ? 32'h0000_0100 + k : 32'h0;
         pop = 1'b1; tick(); pop = 1'b0; tick();
         n_checks++; if (head_nonce !== exp_head) begin n_fail++; $display("FAIL drain_order_%0d: got %h expected %h", k, head_nonce, exp_head); end
      end
      n_checks++; if (status !== 32'h4000_0000) begin n_fail++; $display("FAIL drain_status: got %h expected %h", status, 32'h4000_0000); end
   endtask

   task automatic test_pop_empty();
      pop = 1'b1; tick(); pop = 1'b0; tick();
      n_checks++; if (status !== 32'h4000_0000) begin n_fail++; $display("FAIL pop_empty_status: got %h expected %h", status, 32'h4000_0000); end
      n_checks++; if (head_nonce !== 32'h0) begin n_fail++; $display("FAIL pop_empty_head: got %h expected %h", head_nonce, 32'h0); end
      irq_seen = 0;
      nonce_found = 2'b01;
      nonce_in[31:0] = 32'h0000_0055;
      tick();
      pop = 1'b1; tick(); pop = 1'b0; tick();
      n_checks++; if (head_nonce !== 32'h0000_0055) begin n_fail++; $display("FAIL grant_pop_empty_head: got %h expected %h", head_nonce, 32'h55); end
      n_checks++; if (status !== 32'hC001_0000) begin n_fail++; $display("FAIL grant_pop_empty_status: got %h expected %h", status, 32'hC001_0000); end
      nonce_found = 2'b00;
      tick();
      n_checks++; if (irq_seen !== 1) begin n_fail++; $display("FAIL refire_irq: got %0d expected 1", irq_seen); end
   endtask

   task automatic test_new_block();
      new_block = 1'b1;
      repeat (65535) tick();
      new_block = 1'b0;
      tick();
      n_checks++; if (status !== 32'h0000_FFFF) begin n_fail++; $display("FAIL epoch_ffff: got %h expected %h", status, 32'h0000_FFFF); end
      nonce_found = 2'b01;
      nonce_in[31:0] = 32'h0000_0077;
      repeat (3) tick();
      n_checks++; if (status !== 32'h8001_FFFF) begin n_fail++; $display("FAIL nb_prefill_status: got %h expected %h", status, 32'h8001_FFFF); end
      n_checks++; if (head_nonce !== 32'h0000_0077) begin n_fail++; $display("FAIL nb_prefill_head: got %h expected %h", head_nonce, 32'h77); end
      nonce_found = 2'b11;
      nonce_in[63:32] = 32'h0000_0088;
      pop = 1'b1;
      new_block = 1'b1;
      tick();
      pop = 1'b0;
      new_block = 1'b0;
      tick();
      n_checks++; if (status !== 32'h0) begin n_fail++; $display("FAIL nb_wrap_status: got %h expected %h", status, 32'h0); end
      irq_seen = 0;
      repeat (4) tick();
      n_checks++; if (status !== 32'h0) begin n_fail++; $display("FAIL nb_no_recapture: got %h expected %h", status, 32'h0); end
      n_checks++; if (head_nonce !== 32'h0) begin n_fail++; $display("FAIL nb_head: got %h expected %h", head_nonce, 32'h0); end
      n_checks++; if (irq_seen !== 0) begin n_fail++; $display("FAIL nb_irq: got %0d expected 0", irq_seen); end
   endtask

   task automatic test_async_reset();
      nonce_found = 2'b00;
      tick();
      nonce_found = 2'b01;
      nonce_in[31:0] = 32'h0000_0099;
      repeat (3) tick();
      n_checks++; if (head_nonce !== 32'h0000_0099) begin n_fail++; $display("FAIL ar_prefill: got %h expected %h", head_nonce, 32'h99); end
      pop = 1'b1;
      tick();
      #2;
      rst_main_n = 1'b0;
      #1;
      n_checks++; if (head_nonce !== 32'h0) begin n_fail++; $display("FAIL ar_head: got %h expected %h", head_nonce, 32'h0); end
      n_checks++; if (status !== 32'h0) begin n_fail++; $display("FAIL ar_status: got %h expected %h", status, 32'h0); end
      n_checks++; if (found_irq !== 1'b0) begin n_fail++; $display("FAIL ar_irq: got %b expected 0", found_irq); end
      pop = 1'b0;
      nonce_found = 2'b00;
      @(negedge clk_main_a0);
      rst_main_n = 1'b1;
      tick();
      n_checks++; if (status !== 32'h0) begin n_fail++; $display("FAIL ar_after_release: got %h expected %h", status, 32'h0); end
   endtask

   initial begin
      test_reset();
      test_single_find();
      test_simultaneous();
      test_full_overflow();
      test_pop_empty();
      test_new_block();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
